adc_spi_responder: RTL and testbench

Synthesizable device-side model of the LTC2308-style 12-bit, 8-channel SPI ADC that the HPS system's `adc_0` controller drives through `sclk`/`cs_n`/`din`/`dout`. It decodes the 6-bit configuration word shifted in on `din` and shifts out the previous frame's conversion result on `dout`, MSB first, with the LTC2308's one-frame pipeline. Channel values come from a parallel input bus, so the block serves both as a hardware-in-the-loop sensor emulator and as the bench responder for the ADC controller.

---
 rtl/adc_spi_responder.sv | 177 +++++++++++++++++
 tb/tb_adc_spi_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Device-side model of an LTC2308-style 12-bit, 8-channel SPI ADC. It
// decodes the 6-bit config word {SD, OS, S1, S0, UNI, SLP} shifted in on
// adc_din and shifts the previous frame's result out on adc_dout, MSB first.
// The result is pipelined by one frame, as on the real part.
//
// Ports:
//   clk            system clock, at least 4x the SCLK frequency
//   reset_n        asynchronous active-low reset
//   adc_sclk       SPI clock from the controller (asynchronous)
//   adc_cs_n       frame select, active low (asynchronous)
//   adc_din        config bits, MSB first (asynchronous)
//   adc_dout       result bits, MSB first (registered)
//   chan_data      eight 12-bit channel values, channel n at [12n+11:12n]
//   cfg            last committed config word
//   cfg_valid      one-cycle pulse when cfg is committed
//   frame_count    number of committed frames, wraps 0xFFFF -> 0
//   conv_violation sticky flag: a frame started during the conversion time
//   fsm_state      debug view of the frame FSM (0 idle, 1 shift, 2 conv)
//
// Optional feature macro: ADC_RESP_NOISE_EN adds a 16-bit LFSR whose two
// LSBs perturb result[1:0] at every committed frame (sleep result stays 0).
module adc_spi_responder #(
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        adc_sclk,
    input  logic        adc_cs_n,
    input  logic        adc_din,
    output logic        adc_dout,
    input  logic [95:0] chan_data,
    output logic [5:0]  cfg,
    output logic        cfg_valid,
    output logic [15:0] frame_count,
    output logic        conv_violation,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CONV = 2'd2} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(CONV_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  sclk_sr, cs_sr, din_sr;   // [0]=FF1, [1]=FF2, [2]=edge reg
    logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic        enter_shift, frame_end, commit;
    logic [5:0]  cfg_sr;
    logic [11:0] out_sr;
    logic [11:0] result, new_result, ch_val;
    logic [2:0]  ch_idx;
    logic [3:0]  rcnt, fcnt;
    logic [15:0] timer;
    logic [1:0]  noise;

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sr <= 3'b000;
            cs_sr   <= 3'b111;
            din_sr  <= 3'b000;
        end else begin
            sclk_sr <= {sclk_sr[1:0], adc_sclk};
            cs_sr   <= {cs_sr[1:0], adc_cs_n};
            din_sr  <= {din_sr[1:0], adc_din};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        enter_shift = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = SHIFT;
                    enter_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = CONV;
                    frame_end  = 1'b1;
                end
            end
            CONV: begin
                if (cs_fall) begin
                    state_next  = SHIFT;
                    enter_shift = 1'b1;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign commit = frame_end && (rcnt >= 4'd6);

    // Differential mode (SD=0) always reads the even channel of the pair.
    always_comb begin
        ch_idx = cfg_sr[5] ? {cfg_sr[3], cfg_sr[2], cfg_sr[4]}
                           : {cfg_sr[3], cfg_sr[2], 1'b0};
        ch_val = chan_data[12*ch_idx +: 12];
        new_result = ch_val ^ (cfg_sr[1] ? 12'h000 : 12'h800);
        new_result[1:0] = new_result[1:0] ^ noise;
        if (cfg_sr[0]) new_result = 12'h000;
    end

`ifdef ADC_RESP_NOISE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    lfsr <= 16'hACE1;
        else if (commit) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign noise = lfsr[1:0];
`else
    assign noise = 2'b00;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_dout       <= 1'b0;
            cfg            <= 6'b100010;
            cfg_valid      <= 1'b0;
            frame_count    <= 16'd0;
            conv_violation <= 1'b0;
            result         <= 12'h000;
            out_sr         <= 12'h000;
            cfg_sr         <= 6'd0;
            rcnt           <= 4'd0;
            fcnt           <= 4'd0;
            timer          <= 16'd0;
        end else begin
            cfg_valid <= commit;
            if (enter_shift) begin
                out_sr   <= result;
                adc_dout <= result[11];
                rcnt     <= 4'd0;
                fcnt     <= 4'd0;
                if (state == CONV) conv_violation <= 1'b1;
            end else if (state == SHIFT) begin
                if (sclk_rise) begin
                    if (rcnt < 4'd6) cfg_sr <= {cfg_sr[4:0], din_sr[1]};
                    if (rcnt != 4'd15) rcnt <= rcnt + 4'd1;
                end
                if (sclk_fall) begin
                    out_sr   <= {out_sr[10:0], 1'b0};
                    // After the 12th falling edge the line is held low.
                    adc_dout <= (fcnt < 4'd11) ? out_sr[10] : 1'b0;
                    if (fcnt != 4'd15) fcnt <= fcnt + 4'd1;
                end
            end
            if (frame_end) begin
                timer <= 16'd0;
            end else if (state == CONV && timer != TIMER_LAST) begin
                timer <= timer + 16'd1;
            end
            if (commit) begin
                cfg         <= cfg_sr;
                result      <= new_result;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a driver issues SPI frames, a reference model
// predicts the result each full frame should shift out and queues it, and a
// monitor reassembles adc_dout at every SCLK rising edge and compares.
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adc_sclk = 1'b0;
    logic        adc_cs_n = 1'b1;
    logic        adc_din = 1'b0;
    logic        adc_dout;
    logic [95:0] chan_data = '0;
    logic [5:0]  cfg;
    logic        cfg_valid;
    logic [15:0] frame_count;
    logic        conv_violation;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    logic [11:0] exp_q[$];

    // reference model state
    logic [11:0] m_result;
    logic [5:0]  m_cfg;
    logic [15:0] m_fc;
    int          m_pulses;
    logic        m_viol;
    logic [15:0] m_lfsr;

    adc_spi_responder #(.CONV_CYCLES(80)) dut (
        .clk(clk), .reset_n(reset_n), .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n),
        .adc_din(adc_din), .adc_dout(adc_dout), .chan_data(chan_data),
        .cfg(cfg), .cfg_valid(cfg_valid), .frame_count(frame_count),
        .conv_violation(conv_violation), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_valid) pulse_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] chan(input int n);
        logic [95:0] d;
        d = chan_data;
        return d[12*n +: 12];
    endfunction

    task automatic model_reset();
        m_result = 12'h000;
        m_cfg    = 6'b100010;
        m_fc     = 16'd0;
        m_viol   = 1'b0;
        m_lfsr   = 16'hACE1;
    endtask

    // cfg = {SD, OS, S1, S0, UNI, SLP}
    task automatic model_commit(input logic [5:0] c);
        int n;
        logic [11:0] v;
        n = c[5] ? (c[3] * 4 + c[2] * 2 + c[4]) : (c[3] * 4 + c[2] * 2);
        v = chan(n);
        if (!c[1]) v = v ^ 12'h800;
`ifdef ADC_RESP_NOISE_EN
        v[1:0] = v[1:0] ^ m_lfsr[1:0];
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        if (c[0]) v = 12'h000;
        m_result = v;
        m_cfg    = c;
        m_fc     = m_fc + 16'd1;
        m_pulses++;
    endtask

    // driver: SCLK half period is 5 clk cycles
    task automatic do_frame(input logic [5:0] c, input int nrise, input int gap);
        if (nrise == 12) exp_q.push_back(m_result);
        if (m_fc != 16'd0 || m_pulses != 0) begin end
        adc_din  = c[5];
        adc_cs_n = 1'b0;
        for (int i = 0; i < nrise; i++) begin
            adc_din = (i < 6) ? c[5-i] : 1'b0;
            repeat (5) @(negedge clk);
            adc_sclk = 1'b1;
            repeat (5) @(negedge clk);
            adc_sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        adc_cs_n = 1'b1;
        adc_din  = 1'b0;
        if (nrise >= 6) model_commit(c);
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cfg"}, 32'(cfg), 32'(m_cfg));
        check({tag, "_frame_count"}, 32'(frame_count), 32'(m_fc));
        check({tag, "_cfg_valid_pulses"}, pulse_cnt, m_pulses);
        check({tag, "_conv_violation"}, 32'(conv_violation), 32'(m_viol));
    endtask

    // monitor: one word per full 12-bit frame
    initial begin
        logic [11:0] word;
        logic [11:0] exp;
        int bits;
        forever begin
            @(negedge adc_cs_n);
            bits = 0;
            word = '0;
            while (adc_cs_n == 1'b0) begin
                @(posedge adc_sclk or posedge adc_cs_n);
                if (adc_cs_n == 1'b0 && adc_sclk == 1'b1) begin
                    word = {word[10:0], adc_dout};
                    bits++;
                end
            end
            if (bits == 12) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout_word got 0x%0h expected none queued", word);
                end else begin
                    exp = exp_q.pop_front();
                    check("dout_word", 32'(word), 32'(exp));
                end
            end
        end
    end

    initial begin
        logic [5:0] c;
        int nr;
        m_pulses = 0;
        model_reset();
        repeat (4) @(negedge clk);
        check("rst_dout", 32'(adc_dout), 32'd0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        check_state("rst");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // basic pipeline
        chan_data[11:0] = 12'hABC;
        do_frame(6'b100010, 12, 90);
        do_frame(6'b100010, 12, 90);
        check_state("basic");

        // channel select
        chan_data[23:12] = 12'h123;
        chan_data[83:72] = 12'h456;
        do_frame(6'b110010, 12, 90);
        do_frame(6'b101110, 12, 90);
        do_frame(6'b100010, 12, 90);
        check_state("chsel");

        // bipolar
        chan_data[11:0] = 12'h000;
        do_frame(6'b100000, 12, 90);
        do_frame(6'b100010, 12, 90);
        check_state("bipolar");

        // aborted frame, then a full frame repeats the previous result
        do_frame(6'b110110, 4, 90);
        check_state("abort");
        do_frame(6'b100010, 12, 90);

        // conversion-time violation, sticky through legal frames
        do_frame(6'b100010, 12, 10);
        m_viol = 1'b1;
        do_frame(6'b100010, 12, 90);
        check_state("viol");
        do_frame(6'b101010, 12, 90);
        check_state("viol_sticky");

        // randomized frames
        for (int k = 0; k < 25; k++) begin
            chan_data = {$urandom(), $urandom(), $urandom()};
            c  = 6'($urandom_range(0, 63));
            nr = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 12;
            do_frame(c, nr, 90);
        end
        check_state("random");

        // reset in the middle of a frame
        chan_data[11:0] = 12'hFFF;
        do_frame(6'b100010, 12, 90);
        do_frame(6'b100010, 12, 90);
        adc_cs_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            adc_din = 1'b0;
            repeat (5) @(negedge clk);
            adc_sclk = 1'b1;
            repeat (5) @(negedge clk);
            adc_sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("midframe_dout", 32'(adc_dout), 32'(m_result[6]));
        reset_n = 1'b0;
        #1;
        check("reset_dout", 32'(adc_dout), 32'd0);
        check("reset_cfg", 32'(cfg), 32'b100010);
        model_reset();
        adc_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        do_frame(6'b100010, 12, 90);
        check_state("post_reset");

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
